// File: rtl/ps2_keycode_decoder_pkg.sv
// Shared PS/2 receiver states, prefix bytes, game-key scancodes and
// the HID usage codes also consumed by the harry motion block.
package ps2_keycode_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_SPACE = 8'h29;

    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_S     = 8'h16;
    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_SPACE = 8'h2C;

    function automatic logic [7:0] sc_to_hid(input logic [7:0] sc);
        case (sc)
            SC_A:     sc_to_hid = HID_A;
            SC_D:     sc_to_hid = HID_D;
            SC_S:     sc_to_hid = HID_S;
            SC_W:     sc_to_hid = HID_W;
            SC_SPACE: sc_to_hid = HID_SPACE;
            default:  sc_to_hid = HID_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ps2_keycode_decoder_rx.sv
// PS/2 serial framing: synchronizer, start/data/parity/stop FSM and
// a watchdog that abandons a stalled frame.
module ps2_rx
    import ps2_keycode_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_err,
    output logic       o_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic          r_clk_s1, r_clk_s2, r_clk_prev;
    logic          r_dat_s1, r_dat_s2;
    rx_state_t     r_state, w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par_err;
    logic [CW-1:0] r_idle_cnt;
    logic [7:0]    r_byte;
    logic          r_byte_valid, r_err, r_timeout;
    logic          w_fall, w_tmo;

    assign w_fall = r_clk_prev & ~r_clk_s2;
    assign w_tmo  = (r_state != ST_IDLE) &&
                    (r_idle_cnt == CW'(TIMEOUT_CYCLES));

    always_comb begin
        w_state_nxt = r_state;
        if (w_tmo) begin
            w_state_nxt = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!r_dat_s2) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_clk_prev   <= 1'b1;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_par_err    <= 1'b0;
            r_idle_cnt   <= '0;
            r_byte       <= 8'h00;
            r_byte_valid <= 1'b0;
            r_err        <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_clk_s1     <= ps2_clk;
            r_clk_s2     <= r_clk_s1;
            r_clk_prev   <= r_clk_s2;
            r_dat_s1     <= ps2_data;
            r_dat_s2     <= r_dat_s1;
            r_state      <= w_state_nxt;
            r_byte_valid <= 1'b0;
            r_err        <= 1'b0;
            r_timeout    <= 1'b0;

            if (r_state == ST_IDLE || w_fall || w_tmo)
                r_idle_cnt <= '0;
            else
                r_idle_cnt <= r_idle_cnt + 1'b1;

            if (w_tmo) begin
                r_err     <= 1'b1;
                r_timeout <= 1'b1;
                r_bit_cnt <= 3'd0;
            end else if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        r_bit_cnt <= 3'd0;
                        r_par_err <= 1'b0;
                    end
                    ST_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    // odd parity: data bits plus parity bit must XOR to 1
                    ST_PARITY: r_par_err <= ~(^r_shift ^ r_dat_s2);
                    default: begin
                        if (r_dat_s2 && !r_par_err) begin
                            r_byte       <= r_shift;
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;
    assign o_err        = r_err;
    assign o_timeout    = r_timeout;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard to game-key HID usage: prefix tracking (F0/E0) and
// a single held-key register with change pulse.
module ps2_keycode_decoder
    import ps2_keycode_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0] w_rx_byte;
    logic       w_rx_valid, w_rx_err, w_rx_tmo;
    logic [7:0] w_usage, w_next_key;
    logic       w_is_prefix;
    logic [7:0] r_keycode;
    logic       r_key_valid, r_brk, r_ext;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .Clk         (Clk),
        .Reset       (Reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .o_byte      (w_rx_byte),
        .o_byte_valid(w_rx_valid),
        .o_err       (w_rx_err),
        .o_timeout   (w_rx_tmo)
    );

    assign w_usage     = sc_to_hid(w_rx_byte);
    assign w_is_prefix = (w_rx_byte == PS2_BREAK) || (w_rx_byte == PS2_EXT);

    always_comb begin
        w_next_key = r_keycode;
        if (w_rx_valid && !w_is_prefix && !r_ext && w_usage != HID_NONE) begin
            if (!r_brk)
                w_next_key = w_usage;
            else if (r_keycode == w_usage)
                w_next_key = HID_NONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_keycode   <= HID_NONE;
            r_key_valid <= 1'b0;
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
        end else begin
            r_keycode   <= w_next_key;
            r_key_valid <= (w_next_key != r_keycode);
            if (w_rx_tmo) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else if (w_rx_valid) begin
                if (w_rx_byte == PS2_BREAK) begin
                    r_brk <= 1'b1;
                end else if (w_rx_byte == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end
            end
        end
    end

    assign keycode   = r_keycode;
    assign key_valid = r_key_valid;
    assign frame_err = w_rx_err;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Directed bench for ps2_keycode_decoder: table of PS/2 frames with
// expected keycode / pulse counts, plus timeout and reset sequences.
module tb_ps2_keycode_decoder;
    import ps2_keycode_decoder_pkg::*;

    localparam int TMO = 300;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       key_valid;
    logic       frame_err;

    ps2_keycode_decoder #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keycode  (keycode),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        logic [7:0] exp_key;
        int         exp_kv;
        int         exp_fe;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   kv_cnt = 0;
    int   fe_cnt = 0;
    int   kv_cyc = 0;
    int   stop_cyc = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (!Reset && key_valid) begin
            kv_cnt = kv_cnt + 1;
            kv_cyc = cyc;
        end
        if (!Reset && frame_err) fe_cnt = fe_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic ps2_bit(input logic b, input logic last);
        ps2_data = b;
        wait_cyc(5);
        if (last) stop_cyc = cyc;
        ps2_clk = 1'b0;
        wait_cyc(10);
        ps2_clk = 1'b1;
        wait_cyc(5);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par,
                              input logic bad_stop);
        logic par;
        par = ~(^d) ^ bad_par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit(~bad_stop, 1'b1);
        ps2_data = 1'b1;
        wait_cyc(20);
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits - 1; i++) ps2_bit(d[i], 1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic add(input logic [7:0] d, input logic bp, input logic bs,
                       input logic [7:0] k, input int kv, input int fe);
        vec_t v;
        v.data = d; v.bad_par = bp; v.bad_stop = bs;
        v.exp_key = k; v.exp_kv = kv; v.exp_fe = fe;
        vecs.push_back(v);
    endtask

    initial begin
        int kv0, fe0;

        add(8'h1C, 0, 0, 8'h04, 1, 0);
        add(8'h23, 0, 0, 8'h07, 1, 0);
        add(8'hF0, 0, 0, 8'h07, 0, 0);
        add(8'h1C, 0, 0, 8'h07, 0, 0);
        add(8'hF0, 0, 0, 8'h07, 0, 0);
        add(8'h23, 0, 0, 8'h00, 1, 0);
        add(8'h1D, 1, 0, 8'h00, 0, 1);
        add(8'h1D, 0, 0, 8'h1A, 1, 0);
        add(8'h1D, 0, 0, 8'h1A, 0, 0);
        add(8'hE0, 0, 0, 8'h1A, 0, 0);
        add(8'h1C, 0, 0, 8'h1A, 0, 0);
        add(8'h1C, 0, 0, 8'h04, 1, 0);
        add(8'hF0, 0, 0, 8'h04, 0, 0);
        add(8'h1D, 0, 0, 8'h04, 0, 0);
        add(8'h55, 0, 1, 8'h04, 0, 1);
        add(8'h55, 0, 0, 8'h04, 0, 0);
        add(8'h29, 0, 0, 8'h2C, 1, 0);
        add(8'h29, 0, 0, 8'h2C, 0, 0);
        add(8'h29, 0, 0, 8'h2C, 0, 0);
        add(8'hE0, 0, 0, 8'h2C, 0, 0);
        add(8'hF0, 0, 0, 8'h2C, 0, 0);
        add(8'h29, 0, 0, 8'h2C, 0, 0);
        add(8'hF0, 0, 0, 8'h2C, 0, 0);
        add(8'h29, 0, 0, 8'h00, 1, 0);

        wait_cyc(4);
        check("reset_keycode", keycode, 0);
        check("reset_key_valid", key_valid, 0);
        check("reset_frame_err", frame_err, 0);
        Reset = 1'b0;
        wait_cyc(5);

        foreach (vecs[i]) begin
            kv0 = kv_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
            check($sformatf("v%0d_keycode", i), keycode, vecs[i].exp_key);
            check($sformatf("v%0d_kv", i), kv_cnt - kv0, vecs[i].exp_kv);
            check($sformatf("v%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
            // 2 synchronizer cycles + 2 cycles from detected edge
            if (vecs[i].exp_kv == 1)
                check($sformatf("v%0d_latency", i), kv_cyc - stop_cyc, 4);
        end

        // timeout abandons the frame and clears a pending break flag
        send_frame(8'h1C, 0, 0);
        check("tmo_pre_key", keycode, 8'h04);
        send_frame(8'hF0, 0, 0);
        fe0 = fe_cnt;
        send_partial(8'h29, 5);
        wait_cyc(TMO + 20);
        check("tmo_fe", fe_cnt - fe0, 1);
        check("tmo_idle", int'(dut.u_rx.r_state), int'(ST_IDLE));
        kv0 = kv_cnt;
        send_frame(8'h29, 0, 0);
        check("tmo_next_key", keycode, 8'h2C);
        check("tmo_next_kv", kv_cnt - kv0, 1);

        // reset mid-frame
        fe0 = fe_cnt;
        send_partial(8'h1B, 5);
        Reset = 1'b1;
        wait_cyc(3);
        check("rst_mid_keycode", keycode, 0);
        check("rst_mid_key_valid", key_valid, 0);
        check("rst_mid_frame_err", frame_err, 0);
        Reset = 1'b0;
        wait_cyc(TMO + 20);
        check("rst_mid_no_fe", fe_cnt - fe0, 0);
        kv0 = kv_cnt;
        send_frame(8'h1B, 0, 0);
        check("rst_after_key", keycode, 8'h16);
        check("rst_after_kv", kv_cnt - kv0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_keycode_decoder.md
PS2_KEYCODE_DECODER -- requirements
Module: ps2_keycode_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the number of Clk cycles without a ps2_clk falling edge after which a partial frame is abandoned.
REQ-002 Clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 ps2_clk  input  1  PS/2 keyboard clock, asynchronous to Clk.
REQ-005 ps2_data  input  1  PS/2 keyboard data, asynchronous to Clk.
REQ-006 keycode  output  8  HID usage code of the currently held game key; 8'h00 when no mapped key is held; consumed by the harry motion block.
REQ-007 key_valid  output  1  one-cycle pulse whenever keycode changes value.
REQ-008 frame_err  output  1  one-cycle pulse on a parity error, a stop-bit error or a timeout.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is detected when the synchronized ps2_clk is 1 on the previous Clk cycle and 0 on the current one.
REQ-010 The receiver FSM SHALL have the states IDLE, DATA, PARITY and STOP, and SHALL sample ps2_data only on a detected falling edge.
REQ-011 IDLE: a falling edge with data 0 SHALL go to DATA with the bit counter at 0; a falling edge with data 1 SHALL be ignored.
REQ-012 DATA: 8 bits SHALL be shifted in LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-013 PARITY: the sampled bit SHALL make the 9-bit total odd; a mismatch SHALL be recorded and the FSM SHALL go to STOP.
REQ-014 STOP: the sampled bit SHALL be 1, and the FSM SHALL return to IDLE; on a good parity and a good stop bit the byte SHALL be delivered the following cycle; otherwise frame_err SHALL pulse and the byte SHALL be discarded.
REQ-015 In any state other than IDLE, when the idle counter reaches TIMEOUT_CYCLES the FSM SHALL return to IDLE, pulse frame_err, and clear the break and extended flags; the counter SHALL reset on every falling edge.
REQ-016 A delivered byte 8'hF0 SHALL set the break flag, and a delivered byte 8'hE0 SHALL set the extended flag; neither changes keycode.
REQ-017 Any other delivered byte SHALL be a scancode; both flags SHALL clear after it is processed.
REQ-018 Map table: 1C->04 (A), 23->07 (D), 1B->16 (S), 1D->1A (W), 29->2C (space); any other scancode, and any scancode carrying the extended flag, SHALL be unmapped and SHALL leave keycode unchanged.
REQ-019 Make of a mapped key SHALL set keycode to its usage code (latest press wins).
REQ-020 Break of a mapped key SHALL set keycode to 8'h00 only if keycode equals that key's usage; otherwise keycode SHALL be unchanged.
REQ-021 keycode SHALL update exactly 2 Clk cycles after the falling edge that samples the stop bit, and key_valid SHALL pulse in that same cycle only if the value differs from the previous one (typematic repeats produce no pulse).

Reset
REQ-022 While Reset is high: FSM=IDLE, bit counter=0, shift register=0, idle counter=0, both flags=0, synchronizer flops=1, keycode=8'h00, key_valid=0, frame_err=0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame without a frame_err pulse; the first frame after reset SHALL decode normally.

Structure
REQ-024 A shared package SHALL hold the FSM state enum, the PS/2 prefix constants (F0, E0), the scancode constants and the HID usage constants shared with harry.
REQ-025 The serial framing SHALL be a sub-module ps2_rx (synchronizer, FSM, timeout; outputs byte, byte_valid, err); the top SHALL hold the prefix flags and the map.

Verification
REQ-026 Frame 1C with good parity -> keycode=04 and key_valid pulses once, 2 cycles after the stop-bit edge.
REQ-027 Sequence 1C, 23, F0 1C -> keycode 04, then 07, then stays 07; F0 23 -> 00; three key_valid pulses in total.
REQ-028 Frame 1D with a flipped parity bit -> frame_err pulses once and keycode is unchanged; a following good 1D frame -> 1A.
REQ-029 Send 5 bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulses once and the FSM is IDLE; a next good 29 frame -> 2C.
REQ-030 E0 1C -> keycode unchanged; repeated 29 29 29 -> keycode 2C with only one key_valid pulse.
REQ-031 Reset asserted after 4 data bits -> all outputs 0 and no frame_err; a good 1B frame afterwards -> keycode 16.
